id_stage_pipelined: RTL and testbench

//   Parametrised instruction-decode stage with an integrated ID/EX pipeline register.

---
 rtl/id_stage_pipelined.sv | 161 ++++++++++++++++
 tb/tb_id_stage_pipelined.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// id_stage_pipelined
//   Instruction-decode stage of the pipelined MIPS core with its ID/EX pipeline
//   register built in. It decodes the fields of the instruction and picks the
//   destination register. It also sign- or zero-extends the immediate and the
//   shamt field. Operands come from an internal register file, which has a
//   write-to-read bypass so that a WB write is seen in the same cycle. A
//   load-use hazard detector stalls IF for one cycle and inserts a bubble.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   id_valid             instruction in ID is valid
//   instruction          32-bit instruction word from IF/ID
//   id_pc_plus4          PC+4 of the instruction in ID
//   id_ctrl              opaque control bundle for the instruction in ID
//   id_mem_read          instruction in ID is a load
//   wb_reg_write         WB write enable
//   wb_write_reg         WB destination register
//   wb_write_data        WB write data
//   flush                discard the instruction in ID
//   stall                hold PC and IF/ID this cycle (combinational)
//   ex_*                 registered ID/EX fields handed to the EX stage
// -----------------------------------------------------------------------------
module id_stage_pipelined #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_read_data1,
  output logic [DATA_W-1:0] ex_read_data2,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [DATA_W-1:0] ex_shamt_ext,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_write_reg
);

  localparam int NREGS = 2 ** REG_AW;

  // Decoded fields and combinational ID results
  logic [5:0]        opcode_s;
  logic [REG_AW-1:0] rs_s;
  logic [REG_AW-1:0] rt_s;
  logic [REG_AW-1:0] rd_s;
  logic [REG_AW-1:0] dest_s;
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic [DATA_W-1:0] shamt_ext_s;
  logic              hazard_s;
  logic              bubble_s;
  logic              wb_active_s;

  // Register file storage. Entry 0 is never written, so it always reads 0.
  logic [DATA_W-1:0] regs_r [NREGS];

  assign opcode_s    = instruction[31:26];
  assign rs_s        = instruction[21 +: REG_AW];
  assign rt_s        = instruction[16 +: REG_AW];
  assign rd_s        = instruction[11 +: REG_AW];
  assign imm_ext_s   = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
  assign shamt_ext_s = {{(DATA_W-5){1'b0}}, instruction[10:6]};

  // A WB write only has an effect (and only bypasses) for a nonzero register.
  assign wb_active_s = wb_reg_write && (wb_write_reg != {REG_AW{1'b0}});

  // Destination register select: R-type writes rd, jal writes the link register, others rt
  always_comb begin
    dest_s = rt_s;
    case (opcode_s)
      6'd0:    dest_s = rd_s;
      6'd3:    dest_s = {REG_AW{1'b1}};
      default: dest_s = rt_s;
    endcase
  end

  // Register file reads with same-cycle WB bypass
  always_comb begin
    rdata1_s = regs_r[rs_s];
    rdata2_s = regs_r[rt_s];
    if (wb_active_s && (wb_write_reg == rs_s)) begin
      rdata1_s = wb_write_data;
    end else begin
      rdata1_s = regs_r[rs_s];
    end
    if (wb_active_s && (wb_write_reg == rt_s)) begin
      rdata2_s = wb_write_data;
    end else begin
      rdata2_s = regs_r[rt_s];
    end
  end

  // Load-use hazard: a load in EX whose result is a source operand of the instruction in ID.
  // The stall is suppressed by flush, because the instruction in ID is being discarded anyway.
  always_comb begin
    hazard_s = ex_valid && ex_mem_read && (ex_write_reg != {REG_AW{1'b0}}) &&
               ((ex_write_reg == rs_s) || (ex_write_reg == rt_s));
    stall    = hazard_s && id_valid && !flush;
    bubble_s = flush || stall || !id_valid;
  end

  // Register file write port; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_active_s) begin
      regs_r[wb_write_reg] <= wb_write_data;
    end else begin
      regs_r[wb_write_reg] <= regs_r[wb_write_reg];
    end
  end

  // ID/EX pipeline register. A bubble loads all fields as zero, which also
  // clears ex_mem_read, so a load-use stall lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset || bubble_s) begin
      ex_valid      <= 1'b0;
      ex_ctrl       <= {CTRL_W{1'b0}};
      ex_mem_read   <= 1'b0;
      ex_read_data1 <= {DATA_W{1'b0}};
      ex_read_data2 <= {DATA_W{1'b0}};
      ex_imm_ext    <= {DATA_W{1'b0}};
      ex_shamt_ext  <= {DATA_W{1'b0}};
      ex_pc_plus4   <= {DATA_W{1'b0}};
      ex_rs         <= {REG_AW{1'b0}};
      ex_rt         <= {REG_AW{1'b0}};
      ex_write_reg  <= {REG_AW{1'b0}};
    end else begin
      ex_valid      <= 1'b1;
      ex_ctrl       <= id_ctrl;
      ex_mem_read   <= id_mem_read;
      ex_read_data1 <= rdata1_s;
      ex_read_data2 <= rdata2_s;
      ex_imm_ext    <= imm_ext_s;
      ex_shamt_ext  <= shamt_ext_s;
      ex_pc_plus4   <= id_pc_plus4;
      ex_rs         <= rs_s;
      ex_rt         <= rt_s;
      ex_write_reg  <= dest_s;
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipelined
//   Directed testbench for id_stage_pipelined. It applies a linear sequence of
//   steps with hand-computed expected values and checks each one with an
//   immediate assertion. At the end it prints one summary line.
// -----------------------------------------------------------------------------
module tb_id_stage_pipelined;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [31:0] instruction;
  logic [31:0] id_pc_plus4;
  logic [11:0] id_ctrl;
  logic        id_mem_read;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [11:0] ex_ctrl;
  logic        ex_mem_read;
  logic [31:0] ex_read_data1;
  logic [31:0] ex_read_data2;
  logic [31:0] ex_imm_ext;
  logic [31:0] ex_shamt_ext;
  logic [31:0] ex_pc_plus4;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_write_reg;

  int total = 0;
  int bad   = 0;

  id_stage_pipelined dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .instruction   (instruction),
    .id_pc_plus4   (id_pc_plus4),
    .id_ctrl       (id_ctrl),
    .id_mem_read   (id_mem_read),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .flush         (flush),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .ex_ctrl       (ex_ctrl),
    .ex_mem_read   (ex_mem_read),
    .ex_read_data1 (ex_read_data1),
    .ex_read_data2 (ex_read_data2),
    .ex_imm_ext    (ex_imm_ext),
    .ex_shamt_ext  (ex_shamt_ext),
    .ex_pc_plus4   (ex_pc_plus4),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_write_reg  (ex_write_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(ex_valid), 64'h0);
    check({tag, "_ctrl"},  64'(ex_ctrl),  64'h0);
    check({tag, "_mread"}, 64'(ex_mem_read), 64'h0);
    check({tag, "_rd1"},   64'(ex_read_data1), 64'h0);
    check({tag, "_rd2"},   64'(ex_read_data2), 64'h0);
    check({tag, "_imm"},   64'(ex_imm_ext), 64'h0);
    check({tag, "_shamt"}, 64'(ex_shamt_ext), 64'h0);
    check({tag, "_pc4"},   64'(ex_pc_plus4), 64'h0);
    check({tag, "_rs"},    64'(ex_rs), 64'h0);
    check({tag, "_rt"},    64'(ex_rt), 64'h0);
    check({tag, "_wreg"},  64'(ex_write_reg), 64'h0);
    check({tag, "_stall"}, 64'(stall), 64'h0);
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; instruction = 32'h0; id_pc_plus4 = 32'h0;
    id_ctrl = 12'h0; id_mem_read = 1'b0; wb_reg_write = 1'b0; wb_write_reg = 5'd0;
    wb_write_data = 32'h0; flush = 1'b0;

    // Reset for two cycles
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Read r5 after reset
    id_valid = 1'b1; instruction = rtype(5'd5, 5'd5, 5'd12, 5'd0); id_ctrl = 12'h00F;
    tick();
    check("r5_valid", 64'(ex_valid), 64'h1);
    check("r5_rd1", 64'(ex_read_data1), 64'h0);
    check("r5_rd2", 64'(ex_read_data2), 64'h0);

    // WB writes r1=0x11 with no instruction in ID: bubble in ID/EX
    id_valid = 1'b0; wb_reg_write = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'h11;
    tick();
    check("idle_valid", 64'(ex_valid), 64'h0);
    check("idle_ctrl", 64'(ex_ctrl), 64'h0);
    wb_write_reg = 5'd2; wb_write_data = 32'h22;
    tick();
    wb_reg_write = 1'b0;

    // add r3,r1,r2
    id_valid = 1'b1; instruction = rtype(5'd1, 5'd2, 5'd3, 5'd0);
    id_ctrl = 12'hA5A; id_pc_plus4 = 32'h0000_0104;
    tick();
    check("add_valid", 64'(ex_valid), 64'h1);
    check("add_rd1", 64'(ex_read_data1), 64'h11);
    check("add_rd2", 64'(ex_read_data2), 64'h22);
    check("add_wreg", 64'(ex_write_reg), 64'h3);
    check("add_ctrl", 64'(ex_ctrl), 64'hA5A);
    check("add_rs", 64'(ex_rs), 64'h1);
    check("add_rt", 64'(ex_rt), 64'h2);
    check("add_pc4", 64'(ex_pc_plus4), 64'h104);

    // Bypass: WB writes r4 in the same cycle that ID reads r4
    instruction = rtype(5'd4, 5'd0, 5'd8, 5'd0);
    wb_reg_write = 1'b1; wb_write_reg = 5'd4; wb_write_data = 32'h0000_DEAD;
    tick();
    check("byp_rd1", 64'(ex_read_data1), 64'hDEAD);
    check("byp_rd2_r0", 64'(ex_read_data2), 64'h0);
    check("byp_wreg", 64'(ex_write_reg), 64'h8);

    // Write to r0 while ID reads r0: no bypass, and r0 stays 0 afterwards
    instruction = rtype(5'd0, 5'd4, 5'd9, 5'd0);
    wb_write_reg = 5'd0; wb_write_data = 32'h1234_5678;
    tick();
    check("r0w_rd1", 64'(ex_read_data1), 64'h0);
    check("r0w_rd2_r4", 64'(ex_read_data2), 64'hDEAD);
    wb_reg_write = 1'b0;
    tick();
    check("r0_after_rd1", 64'(ex_read_data1), 64'h0);

    // Shift with shamt=5 on r2
    instruction = rtype(5'd0, 5'd2, 5'd10, 5'd5);
    tick();
    check("sll_shamt", 64'(ex_shamt_ext), 64'h5);
    check("sll_rd2", 64'(ex_read_data2), 64'h22);
    check("sll_wreg", 64'(ex_write_reg), 64'd10);

    // Load-use: lw r6,0(r1) then add r7,r6,r6
    instruction = itype(6'h23, 5'd1, 5'd6, 16'h0000); id_mem_read = 1'b1; id_ctrl = 12'h111;
    tick();
    check("lw_mread", 64'(ex_mem_read), 64'h1);
    check("lw_wreg", 64'(ex_write_reg), 64'h6);
    check("lw_rd1", 64'(ex_read_data1), 64'h11);
    instruction = rtype(5'd6, 5'd6, 5'd7, 5'd0); id_mem_read = 1'b0; id_ctrl = 12'h222;
    #1;
    check("lu_stall", 64'(stall), 64'h1);
    tick();
    check("lu_bub_valid", 64'(ex_valid), 64'h0);
    check("lu_bub_ctrl", 64'(ex_ctrl), 64'h0);
    check("lu_bub_mread", 64'(ex_mem_read), 64'h0);
    check("lu_stall_gone", 64'(stall), 64'h0);
    tick();
    check("lu_add_valid", 64'(ex_valid), 64'h1);
    check("lu_add_wreg", 64'(ex_write_reg), 64'h7);
    check("lu_add_ctrl", 64'(ex_ctrl), 64'h222);

    // Flush together with a hazard: flush wins
    instruction = itype(6'h23, 5'd1, 5'd6, 16'h0000); id_mem_read = 1'b1; id_ctrl = 12'h111;
    tick();
    instruction = rtype(5'd6, 5'd6, 5'd7, 5'd0); id_mem_read = 1'b0; id_ctrl = 12'h222;
    flush = 1'b1;
    #1;
    check("fl_stall", 64'(stall), 64'h0);
    tick();
    check("fl_valid", 64'(ex_valid), 64'h0);
    check("fl_ctrl", 64'(ex_ctrl), 64'h0);
    check("fl_mread", 64'(ex_mem_read), 64'h0);
    flush = 1'b0;

    // jal: link register 31, pc_plus4 passes through
    instruction = {6'd3, 26'h000_0040}; id_pc_plus4 = 32'h0000_2004; id_ctrl = 12'h333;
    tick();
    check("jal_wreg", 64'(ex_write_reg), 64'd31);
    check("jal_pc4", 64'(ex_pc_plus4), 64'h2004);
    check("jal_valid", 64'(ex_valid), 64'h1);

    // addi r9,r1,-4
    instruction = itype(6'h08, 5'd1, 5'd9, 16'hFFFC); id_ctrl = 12'h444;
    tick();
    check("addi_imm", 64'(ex_imm_ext), 64'hFFFF_FFFC);
    check("addi_wreg", 64'(ex_write_reg), 64'd9);
    check("addi_rd1", 64'(ex_read_data1), 64'h11);
    check("addi_shamt", 64'(ex_shamt_ext), 64'h1F);

    // Reset asserted in the middle of a load-use stall
    instruction = itype(6'h23, 5'd1, 5'd6, 16'h0000); id_mem_read = 1'b1; id_ctrl = 12'h111;
    tick();
    instruction = rtype(5'd6, 5'd6, 5'd7, 5'd0); id_mem_read = 1'b0; id_ctrl = 12'h222;
    #1;
    check("rs_stall_pre", 64'(stall), 64'h1);
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    reset = 1'b0;

    // Register file was cleared by the reset: r1 reads 0 now
    instruction = rtype(5'd1, 5'd2, 5'd3, 5'd0); id_ctrl = 12'h555;
    tick();
    check("post_rst_rd1", 64'(ex_read_data1), 64'h0);
    check("post_rst_rd2", 64'(ex_read_data2), 64'h0);
    check("post_rst_valid", 64'(ex_valid), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
